fetch_stage: RTL

//  IF stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID register.

---
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory req/gnt/rvalid handshake bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : RV32I IF stage - PC, single-outstanding imem fetch, in-order queue
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall,
  input  wire logic        jb,
  input  wire logic [31:0] jb_target,
  fetch_stage_if.master    imem,
  output logic             f_valid,
  output logic [31:0]      f_pc,
  output logic [31:0]      f_inst
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]             pc_q, pc_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic                    inflight_q, inflight_d;
  logic                    stale_q, stale_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH-1:0][31:0]  pc_buf_q, pc_buf_d;
  logic [DEPTH-1:0][31:0]  inst_buf_q, inst_buf_d;

  logic        resp;
  logic        push;
  logic        pop;
  logic        grant;
  logic        slot_free;
  logic [CW:0] occ;

  assign f_valid = (count_q != '0);
  assign f_pc    = f_valid ? pc_buf_q[rd_ptr_q]   : 32'h0000_0000;
  assign f_inst  = f_valid ? inst_buf_q[rd_ptr_q] : NOP;

  assign pop  = f_valid && !stall && !jb;
  assign resp = imem.rvalid && inflight_q;
  assign push = resp && !stale_q && !jb;

  // Reserve a slot for any response that might land this cycle so a grant never overflows.
  assign occ       = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, (imem.rvalid && !stale_q)};
  assign slot_free = (occ < DEPTH_W);

  assign imem.req  = !rst && !jb && (!inflight_q || imem.rvalid) && slot_free;
  assign imem.addr = pc_q;
  assign grant     = imem.req && imem.gnt;

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_buf_d   = pc_buf_q;
    inst_buf_d = inst_buf_q;

    if (jb) begin
      pc_d       = jb_target;
      inflight_d = inflight_q && !imem.rvalid;
      stale_d    = inflight_q && !imem.rvalid;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (resp) begin
        inflight_d = 1'b0;
        stale_d    = 1'b0;
      end
      if (grant) begin
        pc_d       = pc_q + 32'd4;
        req_addr_d = pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        pc_buf_d[wr_ptr_q]   = req_addr_q;
        inst_buf_d[wr_ptr_q] = imem.rdata;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_buf_q   <= '0;
      inst_buf_q <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_buf_q   <= pc_buf_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

`default_nettype wire
